// File: rtl/pipeline_mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   - Default widths for data, register address, PC and data-memory address.
//   - Encoding of the memory-access FSM states.
package pipeline_mem_stage_pkg;

   localparam int DSIZE_DEF = 16;
   localparam int ASIZE_DEF = 4;
   localparam int ISIZE_DEF = 16;
   localparam int MSIZE_DEF = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      COMPLETE = 2'd2
   } mem_state_t;

endpackage

// File: rtl/pipeline_mem_stage_access_fsm.sv
// Memory access sequencer for the MEM stage.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   start        memory instruction accepted in IDLE
//   ack          data-memory acknowledge
//   state        current FSM state
//   req          registered memory request (high throughout ACCESS)
//   done         ACCESS ends this cycle (ack or timeout)
//   timed_out    ACCESS ends this cycle without an ack
//   err          sticky timeout flag, cleared only by reset
module mem_access_fsm
   import pipeline_mem_stage_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       ack,
   output mem_state_t state,
   output logic       req,
   output logic       done,
   output logic       timed_out,
   output logic       err
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   mem_state_t    state_d;
   logic [CW-1:0] cnt;
   logic          last;

   // cnt counts ACCESS cycles from 0; the cycle holding TIMEOUT-1 is the last one.
   assign last = (cnt == CW'(TIMEOUT - 1));

   always_comb begin
      state_d   = state;
      done      = 1'b0;
      timed_out = 1'b0;
      unique case (state)
         IDLE:     if (start) state_d = ACCESS;
         ACCESS: begin
            // ack takes priority over a coincident timeout
            if (ack) begin
               state_d = COMPLETE;
               done    = 1'b1;
            end else if (last) begin
               state_d   = COMPLETE;
               done      = 1'b1;
               timed_out = 1'b1;
            end
         end
         COMPLETE: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         req   <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_d;
         req   <= (state_d == ACCESS);
         cnt   <= (state == ACCESS && state_d == ACCESS) ? cnt + CW'(1) : '0;
         if (timed_out) err <= 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_mem_stage.sv
// MEM stage: drives the MEM/WB register inputs. Non-memory instructions pass
// straight through combinationally; loads/stores are latched and run over a
// req/ack data-memory port while the stage stalls upstream.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   valid_in .. MemtoReg_in        EX/MEM register contents
//   stall_out                      hold EX/MEM and earlier stages
//   dmem_*                         data-memory request/response
//   wen_out .. readMem_out         MEM/WB register inputs
//   mem_err_out                    sticky memory-timeout flag
module pipeline_mem_stage
   import pipeline_mem_stage_pkg::*;
#(
   parameter int DSIZE   = DSIZE_DEF,
   parameter int ASIZE   = ASIZE_DEF,
   parameter int ISIZE   = ISIZE_DEF,
   parameter int MSIZE   = MSIZE_DEF,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [DSIZE-1:0] alu_result_in,
   input  logic [DSIZE-1:0] store_data_in,
   input  logic             mem_read_in,
   input  logic             mem_write_in,
   input  logic             wen_in,
   input  logic [ASIZE-1:0] w_addr_in,
   input  logic [ISIZE-1:0] PC_in,
   input  logic             jal_in,
   input  logic             MemtoReg_in,
   output logic             stall_out,
   output logic             dmem_req_out,
   output logic             dmem_we_out,
   output logic [MSIZE-1:0] dmem_addr_out,
   output logic [DSIZE-1:0] dmem_wdata_out,
   input  logic             dmem_ack_in,
   input  logic [DSIZE-1:0] dmem_rdata_in,
   output logic             wen_out,
   output logic             jal_out,
   output logic             MemtoReg_out,
   output logic [DSIZE-1:0] w_data_out,
   output logic [ASIZE-1:0] w_addr_out,
   output logic [ISIZE-1:0] PC_out,
   output logic [DSIZE-1:0] readMem_out,
   output logic             mem_err_out
);

   mem_state_t state;
   logic       req, done, timed_out, err;
   logic       is_mem, accept;

   // latched memory instruction
   logic             wen_q, jal_q, m2r_q, we_q;
   logic [ASIZE-1:0] w_addr_q;
   logic [ISIZE-1:0] pc_q;
   logic [DSIZE-1:0] alu_q, wdata_q, rdata_q;
   logic [MSIZE-1:0] addr_q;

   assign is_mem = valid_in & (mem_read_in | mem_write_in);
   assign accept = (state == IDLE) & is_mem;

   mem_access_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .start     (accept),
      .ack       (dmem_ack_in),
      .state     (state),
      .req       (req),
      .done      (done),
      .timed_out (timed_out),
      .err       (err)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wen_q    <= 1'b0;
         jal_q    <= 1'b0;
         m2r_q    <= 1'b0;
         we_q     <= 1'b0;
         w_addr_q <= '0;
         pc_q     <= '0;
         alu_q    <= '0;
         wdata_q  <= '0;
         addr_q   <= '0;
         rdata_q  <= '0;
      end else if (accept) begin
         wen_q    <= wen_in;
         jal_q    <= jal_in;
         m2r_q    <= MemtoReg_in;
         we_q     <= mem_write_in;   // read+write together is treated as a write
         w_addr_q <= w_addr_in;
         pc_q     <= PC_in;
         alu_q    <= alu_result_in;
         wdata_q  <= store_data_in;
         addr_q   <= alu_result_in[MSIZE-1:0];
         rdata_q  <= '0;
      end else if (done) begin
         // timeout implies no ack, so it captures 0 as well
         rdata_q <= (dmem_ack_in && !we_q) ? dmem_rdata_in : '0;
      end
   end

   assign dmem_req_out   = req;
   assign dmem_we_out    = req & we_q;
   assign dmem_addr_out  = req ? addr_q  : '0;
   assign dmem_wdata_out = req ? wdata_q : '0;
   assign mem_err_out    = err;

   // WB-side mux; everything is forced to 0 while reset is held, which also
   // blocks the combinational pass-through path.
   always_comb begin
      stall_out    = 1'b0;
      wen_out      = 1'b0;
      jal_out      = 1'b0;
      MemtoReg_out = 1'b0;
      w_data_out   = '0;
      w_addr_out   = '0;
      PC_out       = '0;
      readMem_out  = '0;
      if (rst) begin
         unique case (state)
            IDLE: begin
               stall_out = is_mem;
               if (valid_in && !is_mem) begin
                  wen_out      = wen_in;
                  jal_out      = jal_in;
                  MemtoReg_out = MemtoReg_in;
                  w_data_out   = alu_result_in;
                  w_addr_out   = w_addr_in;
                  PC_out       = PC_in;
               end
            end
            ACCESS: stall_out = 1'b1;
            COMPLETE: begin
               wen_out      = wen_q;
               jal_out      = jal_q;
               MemtoReg_out = m2r_q;
               w_data_out   = alu_q;
               w_addr_out   = w_addr_q;
               PC_out       = pc_q;
               readMem_out  = rdata_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
module tb_pipeline_mem_stage;
   import pipeline_mem_stage_pkg::*;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0;
   logic        wen_in = 1'b0, jal_in = 1'b0, MemtoReg_in = 1'b0;
   logic [15:0] alu_result_in = '0, store_data_in = '0, PC_in = '0;
   logic [3:0]  w_addr_in = '0;
   logic        dmem_ack_in = 1'b0;
   logic [15:0] dmem_rdata_in = 16'hDEAD;
   logic        stall_out, dmem_req_out, dmem_we_out, mem_err_out;
   logic [7:0]  dmem_addr_out;
   logic [15:0] dmem_wdata_out, w_data_out, PC_out, readMem_out;
   logic        wen_out, jal_out, MemtoReg_out;
   logic [3:0]  w_addr_out;

   always #5 clk = ~clk;

   pipeline_mem_stage #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result_in(alu_result_in),
      .store_data_in(store_data_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .wen_in(wen_in), .w_addr_in(w_addr_in), .PC_in(PC_in), .jal_in(jal_in),
      .MemtoReg_in(MemtoReg_in), .stall_out(stall_out), .dmem_req_out(dmem_req_out),
      .dmem_we_out(dmem_we_out), .dmem_addr_out(dmem_addr_out), .dmem_wdata_out(dmem_wdata_out),
      .dmem_ack_in(dmem_ack_in), .dmem_rdata_in(dmem_rdata_in), .wen_out(wen_out),
      .jal_out(jal_out), .MemtoReg_out(MemtoReg_out), .w_data_out(w_data_out),
      .w_addr_out(w_addr_out), .PC_out(PC_out), .readMem_out(readMem_out),
      .mem_err_out(mem_err_out)
   );

   typedef struct packed {
      logic wen, jal, m2r;
      logic [15:0] wdata;
      logic [3:0]  waddr;
      logic [15:0] pc;
      logic [15:0] rmem;
   } wb_t;

   typedef struct {
      logic valid, rd, wr, wen, jal, m2r;
      logic [15:0] alu, sdata, pc;
      logic [3:0]  waddr;
   } instr_t;

   wb_t  exp_q[$];
   int   checks = 0, errors = 0;
   logic exp_err = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic instr_t mk(input logic v, rd, wr, wen, jal, m2r,
                                 input logic [15:0] alu, sdata, pc, input logic [3:0] wa);
      instr_t i;
      i.valid = v; i.rd = rd; i.wr = wr; i.wen = wen; i.jal = jal; i.m2r = m2r;
      i.alu = alu; i.sdata = sdata; i.pc = pc; i.waddr = wa;
      return i;
   endfunction

   function automatic wb_t obs();
      return {wen_out, jal_out, MemtoReg_out, w_data_out, w_addr_out, PC_out, readMem_out};
   endfunction

   // Every real instruction carries a nonzero PC, so a nonzero PC_out marks a WB output.
   task automatic sample_wb();
      wb_t o, e;
      o = obs();
      if (PC_out != '0) begin
         if (exp_q.size() == 0) chk("wb_unexpected", 64'(o), 64'd0);
         else begin
            e = exp_q.pop_front();
            chk("wb", 64'(o), 64'(e));
         end
      end
   endtask

   // Present one instruction and model the upstream register (advance when not
   // stalled) plus a memory that acks in ACCESS cycle ack_dly (-1: never).
   task automatic run_op(input instr_t i, input int ack_dly, input logic [15:0] rd);
      logic memop, acked;
      int   exp_stall, stalls, acc;
      bit   done;
      wb_t  e;
      stalls = 0; acc = 0; done = 0;
      memop = i.valid && (i.rd || i.wr);
      acked = memop && ack_dly >= 0 && ack_dly < TIMEOUT;
      exp_stall = !memop ? 0 : (acked ? ack_dly + 2 : TIMEOUT + 1);
      valid_in = i.valid; mem_read_in = i.rd; mem_write_in = i.wr;
      wen_in = i.wen; jal_in = i.jal; MemtoReg_in = i.m2r;
      alu_result_in = i.alu; store_data_in = i.sdata; PC_in = i.pc; w_addr_in = i.waddr;
      if (i.valid) begin
         e.wen = i.wen; e.jal = i.jal; e.m2r = i.m2r; e.wdata = i.alu;
         e.waddr = i.waddr; e.pc = i.pc;
         e.rmem = (memop && i.rd && !i.wr && acked) ? rd : 16'h0;
         exp_q.push_back(e);
      end
      for (int c = 0; c < 80 && !done; c++) begin
         @(negedge clk);
         sample_wb();
         if (stall_out) stalls++;
         if (dmem_req_out) begin
            if (acc == 0) begin
               chk("dmem_addr", 64'(dmem_addr_out), 64'(i.alu[7:0]));
               chk("dmem_we", 64'(dmem_we_out), 64'(i.wr));
               if (i.wr) chk("dmem_wdata", 64'(dmem_wdata_out), 64'(i.sdata));
            end
            dmem_ack_in   = (acc == ack_dly);
            dmem_rdata_in = (acc == ack_dly) ? rd : 16'hDEAD;
            acc++;
         end else begin
            dmem_ack_in   = 1'b0;
            dmem_rdata_in = 16'hDEAD;
         end
         done = !stall_out;
         @(posedge clk); #1;
      end
      dmem_ack_in = 1'b0;
      chk("advance", 64'(done), 64'd1);
      chk("stall_cycles", 64'(stalls), 64'(exp_stall));
      chk("req_cycles", 64'(acc), 64'(memop ? exp_stall - 1 : 0));
      if (memop && !acked) exp_err = 1'b1;
      chk("mem_err", 64'(mem_err_out), 64'(exp_err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset held with a valid ALU op on the inputs: everything must be 0
      valid_in = 1'b1; wen_in = 1'b1; alu_result_in = 16'h4321; PC_in = 16'h0099; w_addr_in = 4'd7;
      #12;
      chk("rst_wb", 64'(obs()), 64'd0);
      chk("rst_stall", 64'(stall_out), 64'd0);
      chk("rst_req", 64'(dmem_req_out), 64'd0);
      chk("rst_err", 64'(mem_err_out), 64'd0);
      @(negedge clk); rst = 1'b1; valid_in = 1'b0;
      @(posedge clk); #1;

      // ALU op pass-through
      run_op(mk(1,0,0,1,0,0,16'h1234,16'h0,16'h0010,4'd3), -1, 16'h0);
      // load, immediate ack
      run_op(mk(1,1,0,1,0,1,16'h0A05,16'h0,16'h0012,4'd5), 0, 16'hBEEF);
      // store, ack in 3rd ACCESS cycle
      run_op(mk(1,0,1,0,0,0,16'h0010,16'h00FF,16'h0014,4'd0), 2, 16'h7777);
      // bubble with junk fields must not leak
      run_op(mk(0,0,0,1,1,1,16'hFFFF,16'h0,16'h0F0F,4'd9), -1, 16'h0);
      // read+write together is a write; readMem stays 0
      run_op(mk(1,1,1,1,1,0,16'h3377,16'hA5A5,16'h0016,4'd2), 1, 16'h1111);
      // ack on the last permitted cycle wins over timeout
      run_op(mk(1,1,0,1,0,1,16'h0020,16'h0,16'h0018,4'd4), TIMEOUT - 1, 16'hC0DE);
      // load that never gets an ack
      run_op(mk(1,1,0,1,0,1,16'h0030,16'h0,16'h001A,4'd6), -1, 16'h0);
      // sticky error persists; load then ALU back-to-back
      run_op(mk(1,0,0,1,1,0,16'h5555,16'h0,16'h001C,4'd8), -1, 16'h0);
      run_op(mk(1,1,0,1,0,1,16'h00C3,16'h0,16'h001E,4'd1), 0, 16'h5A5A);
      run_op(mk(1,0,0,1,0,0,16'h6666,16'h0,16'h0020,4'd10), -1, 16'h0);

      // asynchronous reset in the 2nd ACCESS cycle
      valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; alu_result_in = 16'h0044; PC_in = 16'h0022;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_req", 64'(dmem_req_out), 64'd1);
      #2 rst = 1'b0; #1;
      chk("arst_req", 64'(dmem_req_out), 64'd0);
      chk("arst_stall", 64'(stall_out), 64'd0);
      chk("arst_err", 64'(mem_err_out), 64'd0);
      mem_read_in = 1'b0; wen_in = 1'b1; alu_result_in = 16'h2468; #1;
      chk("arst_pass", 64'(obs()), 64'd0);
      exp_err = 1'b0;
      @(negedge clk);
      rst = 1'b1; valid_in = 1'b0; dmem_ack_in = 1'b1; dmem_rdata_in = 16'hBAD1;
      @(posedge clk); #1;
      dmem_ack_in = 1'b0;
      chk("late_ack_req", 64'(dmem_req_out), 64'd0);
      chk("late_ack_stall", 64'(stall_out), 64'd0);
      chk("late_ack_wb", 64'(obs()), 64'd0);

      // normal operation after reset
      run_op(mk(1,1,0,1,0,1,16'h0077,16'h0,16'h0024,4'd11), 1, 16'h9ABC);
      run_op(mk(1,0,0,0,1,0,16'h0101,16'h0,16'h0026,4'd12), -1, 16'h0);

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_mem_stage.md
Name: pipeline_mem_stage

Overview:
- MEM stage: sits between the EX/MEM pipeline register and the MEM/WB register (Pipeline_WB_Stage), and drives that register's inputs.
- Passes non-memory instructions straight through in one cycle.
- Runs loads/stores over a req/ack data-memory interface, stalling upstream until the access completes or times out.
- Holds a sticky error flag for memory timeouts.

Parameters:
- DSIZE, 16, data word width
- ASIZE, 4, register-file address width
- ISIZE, 16, PC width
- MSIZE, 8, data-memory address width
- TIMEOUT, 16, max ACCESS cycles waiting for ack (>=2)

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  reset, asynchronous, active-low
- valid_in  in  1  EX/MEM slot holds a real instruction
- alu_result_in  in  DSIZE  ALU result; memory address for loads/stores
- store_data_in  in  DSIZE  store data
- mem_read_in, mem_write_in  in  1 each  load / store
- wen_in  in  1  register write enable
- w_addr_in  in  ASIZE  destination register
- PC_in  in  ISIZE  PC
- jal_in, MemtoReg_in  in  1 each  writeback selectors
- stall_out  out  1  hold EX/MEM and earlier stages
- dmem_req_out  out  1  memory request
- dmem_we_out  out  1  1 = write
- dmem_addr_out  out  MSIZE  memory address
- dmem_wdata_out  out  DSIZE  write data
- dmem_ack_in  in  1  memory acknowledge (one cycle)
- dmem_rdata_in  in  DSIZE  read data, valid with ack
- wen_out, jal_out, MemtoReg_out  out  1 each  to WB register
- w_data_out  out  DSIZE  ALU result to WB register
- w_addr_out  out  ASIZE  to WB register
- PC_out  out  ISIZE  to WB register
- readMem_out  out  DSIZE  load data to WB register
- mem_err_out  out  1  sticky timeout flag

Behaviour:
- FSM states: IDLE, ACCESS, COMPLETE.
- IDLE, non-memory instruction (valid_in=1, mem_read_in=mem_write_in=0):
  - combinational pass-through: wen/w_addr/PC/jal/MemtoReg from inputs, w_data_out=alu_result_in, readMem_out=0.
  - stall_out=0.
- IDLE, valid_in=0: bubble. wen_out=jal_out=MemtoReg_out=0; data, address and PC outputs 0.
- IDLE, memory op (valid_in & (mem_read_in|mem_write_in)):
  - stall_out=1 combinationally; WB outputs are a bubble.
  - Latch all instruction fields, address=alu_result_in[MSIZE-1:0], and store data; upper address bits are ignored.
  - Next state ACCESS. If both read and write are set, it is a write and readMem_out=0.
- ACCESS:
  - dmem_req_out=1 (registered, first high in the cycle after acceptance); addr/we/wdata driven from latches.
  - stall_out=1; WB outputs are a bubble; cycle counter increments.
  - On dmem_ack_in=1: capture dmem_rdata_in for a read (0 for a write), then go to COMPLETE. dmem_req_out is low next cycle.
  - If the counter reaches TIMEOUT-1 with no ack: go to COMPLETE with captured data 0, and set mem_err_out=1, held until reset.
  - Ack and timeout in the same cycle: ack wins, no error.
- COMPLETE:
  - stall_out=0; WB outputs come from the latches, readMem_out=captured data.
  - Inputs are ignored; upstream advances at this edge. Next state IDLE. Held for exactly 1 cycle.
- dmem_ack_in in IDLE or COMPLETE is ignored.
- Latency:
  - non-memory: 0 extra cycles.
  - memory: min 3 cycles (accept, ACCESS with immediate ack, COMPLETE), i.e. 2 stall cycles.
- Reset (rst=0, asynchronous, any state including mid-ACCESS):
  - state=IDLE; counter, latches and mem_err_out cleared; dmem_req_out=0 immediately.
  - While rst=0, all outputs are 0, including stall_out and the pass-through outputs.
  - An outstanding ack after reset release is ignored.

Decomposition:
- Shared define/package: DSIZE, ASIZE, ISIZE, MSIZE widths; FSM state encodings (IDLE=2'd0, ACCESS=2'd1, COMPLETE=2'd2).
- One sub-module: mem_access_fsm (state, counter, req/timeout). Field latches and output muxing live in the top.

Test Plan:
- ALU op, valid_in=1, alu_result_in=16'h1234, wen_in=1, w_addr_in=4'd3 -> same cycle: w_data_out=16'h1234, wen_out=1, w_addr_out=3, stall_out=0, dmem_req_out stays 0.
- Load from alu_result_in=16'h0A05, ack on 1st ACCESS cycle with rdata=16'hBEEF -> dmem_addr_out=8'h05; stall_out high 2 cycles; COMPLETE shows readMem_out=16'hBEEF, MemtoReg_out=1.
- Store of store_data_in=16'h00FF to address 8'h10, ack after 3 cycles -> dmem_we_out=1, dmem_wdata_out=16'h00FF; stall_out high 4 cycles; COMPLETE shows wen_out=0, readMem_out=0.
- Load, no ack, TIMEOUT=16 -> 16 ACCESS cycles, then COMPLETE with readMem_out=0; mem_err_out=1 persists through later instructions.
- rst driven low in the 2nd ACCESS cycle -> dmem_req_out and stall_out drop asynchronously; after release the FSM is in IDLE with mem_err_out=0; a late ack is ignored.
- Load, then ALU op queued upstream -> ALU op appears on the outputs in the cycle after COMPLETE, with exactly one WB output per instruction and no duplicates.
